ex_mem_stage: RTL

Branch-resolution and EX/MEM pipeline-register stage of the 5-stage RV32I core. It sits directly downstream of the ALU and consumes `alu_out` and `branch_flag` together with the ID/EX control fields. It resolves conditional branches, JAL and JALR against a static not-taken fetch policy, issues a registered PC redirect, and squashes the single wrong-path instruction that reaches EX behind a taken control transfer. It also registers everything the MEM stage needs.

---
 rtl/ex_mem_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// Branch resolution and EX/MEM register: 1-cycle latency, registered redirect that squashes the next EX slot.
// Backpressure: stall holds every register (payload, shadow state, redirect and counter).
module ex_mem_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic [4:0]      ex_rd,
   input  logic            ex_reg_write,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic [2:0]      ex_funct3,
   input  logic [1:0]      ex_br_type,
   input  logic [XLEN-1:0] alu_out,
   input  logic            branch_flag,
   input  logic            stall,
   output logic            mem_valid,
   output logic [XLEN-1:0] mem_result,
   output logic [XLEN-1:0] mem_store_data,
   output logic [4:0]      mem_rd,
   output logic            mem_reg_write,
   output logic            mem_mem_read,
   output logic            mem_mem_write,
   output logic [2:0]      mem_funct3,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            misalign,
   output logic [31:0]     taken_cnt
);

   typedef enum logic {IDLE = 1'b0, SHADOW = 1'b1} state_t;

   localparam logic [1:0] BR_COND = 2'b01;
   localparam logic [1:0] BR_JALR = 2'b11;

   state_t          state_q, state_d;
   logic            mem_valid_q, mem_valid_d;
   logic [XLEN-1:0] mem_result_q, mem_result_d;
   logic [XLEN-1:0] mem_store_data_q, mem_store_data_d;
   logic [4:0]      mem_rd_q, mem_rd_d;
   logic            mem_reg_write_q, mem_reg_write_d;
   logic            mem_mem_read_q, mem_mem_read_d;
   logic            mem_mem_write_q, mem_mem_write_d;
   logic [2:0]      mem_funct3_q, mem_funct3_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     taken_cnt_q, taken_cnt_d;

   logic            accept;
   logic            taken;
   logic            is_jump;
   logic [XLEN-1:0] target;

   always_comb begin
      is_jump = ex_br_type[1];
      taken   = is_jump | ((ex_br_type == BR_COND) & branch_flag);
      target  = (ex_br_type == BR_JALR) ? (alu_out & ~XLEN'(1)) : (ex_pc + ex_imm);
      // An instruction arriving while the shadow is open is on the wrong path.
      accept  = ex_valid & ~stall & (state_q == IDLE);

      state_d          = state_q;
      mem_valid_d      = mem_valid_q;
      mem_result_d     = mem_result_q;
      mem_store_data_d = mem_store_data_q;
      mem_rd_d         = mem_rd_q;
      mem_reg_write_d  = mem_reg_write_q;
      mem_mem_read_d   = mem_mem_read_q;
      mem_mem_write_d  = mem_mem_write_q;
      mem_funct3_d     = mem_funct3_q;
      redirect_pc_d    = redirect_pc_q;
      misalign_d       = misalign_q;
      taken_cnt_d      = taken_cnt_q;

      if (!stall) begin
         mem_valid_d = accept;
         state_d     = IDLE;
         if (accept) begin
            mem_result_d     = is_jump ? (ex_pc + XLEN'(4)) : alu_out;
            mem_store_data_d = ex_rs2_data;
            mem_rd_d         = ex_rd;
            mem_reg_write_d  = ex_reg_write;
            mem_mem_read_d   = ex_mem_read;
            mem_mem_write_d  = ex_mem_write;
            mem_funct3_d     = ex_funct3;
            if (taken) begin
               state_d       = SHADOW;
               redirect_pc_d = target;
               misalign_d    = target[1];
               taken_cnt_d   = taken_cnt_q + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         mem_valid_q      <= 1'b0;
         mem_result_q     <= '0;
         mem_store_data_q <= '0;
         mem_rd_q         <= '0;
         mem_reg_write_q  <= 1'b0;
         mem_mem_read_q   <= 1'b0;
         mem_mem_write_q  <= 1'b0;
         mem_funct3_q     <= '0;
         redirect_pc_q    <= '0;
         misalign_q       <= 1'b0;
         taken_cnt_q      <= '0;
      end else begin
         state_q          <= state_d;
         mem_valid_q      <= mem_valid_d;
         mem_result_q     <= mem_result_d;
         mem_store_data_q <= mem_store_data_d;
         mem_rd_q         <= mem_rd_d;
         mem_reg_write_q  <= mem_reg_write_d;
         mem_mem_read_q   <= mem_mem_read_d;
         mem_mem_write_q  <= mem_mem_write_d;
         mem_funct3_q     <= mem_funct3_d;
         redirect_pc_q    <= redirect_pc_d;
         misalign_q       <= misalign_d;
         taken_cnt_q      <= taken_cnt_d;
      end
   end

   assign mem_valid      = mem_valid_q;
   assign mem_result     = mem_result_q;
   assign mem_store_data = mem_store_data_q;
   assign mem_rd         = mem_rd_q;
   assign mem_reg_write  = mem_reg_write_q;
   assign mem_mem_read   = mem_mem_read_q;
   assign mem_mem_write  = mem_mem_write_q;
   assign mem_funct3     = mem_funct3_q;
   assign redirect_valid = (state_q == SHADOW);
   assign redirect_pc    = redirect_pc_q;
   assign misalign       = misalign_q;
   assign taken_cnt      = taken_cnt_q;

endmodule
